// File: rtl/zrb_uart_rx_os_if.sv
// Purpose: receive-side bundle from the UART receiver to the rx FIFO write port and status logic.
// Latency: none, wires only.
// Backpressure: none; valid is a one-clk write strobe that the FIFO must accept.
interface zrb_uart_rx_os_if;
    logic [8:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       busy;

    modport master (
        output data_out,
        output valid,
        output parity_err,
        output frame_err,
        output break_det,
        output busy
    );

    modport slave (
        input data_out,
        input valid,
        input parity_err,
        input frame_err,
        input break_det,
        input busy
    );
endinterface

// File: rtl/zrb_uart_rx_os.sv
// Purpose: oversampled UART receiver with majority vote, false-start rejection, parity, framing and break detection.
// Latency: 2 clk sync + about (frame bits - 1/2) bit periods of clk_en ticks + 1 clk to the valid strobe.
// Backpressure: none; each frame produces one valid (or break_det) pulse that the consumer must take.
module zrb_uart_rx_os #(
    parameter int    NUM_BITS   = 8,
    parameter string PARITY     = "NO",
    parameter int    STOP_BIT   = 1,
    parameter int    OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             rx,
    zrb_uart_rx_os_if.master rx_if
);

    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;
    localparam bit PAR_EN  = (PARITY != "NO");
    localparam bit PAR_ODD = (PARITY == "ODD");

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;

    logic [SW-1:0] smp;
    logic [3:0]    bit_idx;
    logic          stop_idx;
    logic [1:0]    vote;
    logic [8:0]    shreg;
    logic          perr_lat;
    logic          ferr_lat;

    logic          start_frame;
    logic          bit_inc;
    logic          stop_inc;
    logic          fire_valid;
    logic          fire_brk;

    // First two vote samples live in the register; the third is rx_s itself on the vote clk.
    wire vote_cap  = clk_en && ((smp == SW'(M - 1)) || (smp == SW'(M)));
    wire vote_clk  = clk_en && (smp == SW'(M + 1));
    wire bit_end   = clk_en && (smp == SW'(OVERSAMPLE - 1));
    wire bit_val   = (vote[1] & vote[0]) | (vote[1] & rx_s) | (vote[0] & rx_s);
    wire fall_edge = rx_prev && !rx_s;
    wire data_zero = (shreg == 9'd0);

    // Two-flop synchroniser plus the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-clk control strobes for the datapath.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        bit_inc     = 1'b0;
        stop_inc    = 1'b0;
        fire_valid  = 1'b0;
        fire_brk    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fall_edge) begin
                    state_nxt   = S_START;
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (vote_clk && bit_val) begin
                    state_nxt = S_IDLE;
                end else if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 4'(NUM_BITS - 1)) begin
                        state_nxt = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (vote_clk && (stop_idx == 1'(STOP_BIT - 1))) begin
                    // Leave at mid-bit so a back-to-back start edge is not missed.
                    if (data_zero && !bit_val) begin
                        state_nxt = S_BRK_WAIT;
                        fire_brk  = 1'b1;
                    end else begin
                        state_nxt  = S_IDLE;
                        fire_valid = 1'b1;
                    end
                end else if (bit_end) begin
                    stop_inc = 1'b1;
                end
            end
            S_BRK_WAIT: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sample counter, vote samples and bit/stop indices; all frozen between clk_en ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp      <= '0;
            vote     <= 2'b11;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            if (start_frame || (state_nxt == S_IDLE) || (state_nxt == S_BRK_WAIT)) begin
                smp <= '0;
            end else if (clk_en) begin
                smp <= (smp == SW'(OVERSAMPLE - 1)) ? '0 : smp + 1'b1;
            end
            if (vote_cap) begin
                vote <= {vote[0], rx_s};
            end
            if (start_frame) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
            end else begin
                if (bit_inc) begin
                    bit_idx <= bit_idx + 1'b1;
                end
                if (stop_inc) begin
                    stop_idx <= 1'b1;
                end
            end
        end
    end

    // Shift register and internal parity/framing latches for the frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            perr_lat <= 1'b0;
            ferr_lat <= 1'b0;
        end else if (start_frame) begin
            shreg    <= '0;
            perr_lat <= 1'b0;
            ferr_lat <= 1'b0;
        end else if (vote_clk) begin
            if (state == S_DATA) begin
                shreg[bit_idx] <= bit_val;
            end
            if (state == S_PARITY) begin
                perr_lat <= (^shreg) ^ bit_val ^ PAR_ODD;
            end
            if ((state == S_STOP) && !bit_val) begin
                ferr_lat <= 1'b1;
            end
        end
    end

    // Output word and flags load together on valid and hold until the next valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_if.data_out   <= '0;
            rx_if.valid      <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.frame_err  <= 1'b0;
            rx_if.break_det  <= 1'b0;
        end else begin
            rx_if.valid     <= fire_valid;
            rx_if.break_det <= fire_brk;
            if (fire_valid) begin
                rx_if.data_out   <= shreg;
                rx_if.parity_err <= perr_lat;
                rx_if.frame_err  <= ferr_lat | !bit_val;
            end
        end
    end

    assign rx_if.busy = (state != S_IDLE);

endmodule

// File: tb/tb_zrb_uart_rx_os.sv
module tb_zrb_uart_rx_os;

    logic clk = 1'b0;
    logic reset;
    logic clk_en = 1'b0;
    logic rx_a;
    logic rx_b;

    int n_vec = 0;
    int n_bad = 0;
    int div = 1;
    int ecnt = 0;
    int brk_a_cyc = 0;
    int brk_b_cyc = 0;
    bit busy_chk_a = 1'b0;
    bit busy_chk_b = 1'b0;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    typedef struct {
        int         dut;
        logic [8:0] d;
        logic       par;
        logic [1:0] stops;
        int         dv;
        logic [8:0] xd;
        logic       xpe;
        logic       xfe;
    } vec_t;

    vec_t tv[11];

    zrb_uart_rx_os_if a_if ();
    zrb_uart_rx_os_if b_if ();

    zrb_uart_rx_os #(
        .NUM_BITS(8), .PARITY("NO"), .STOP_BIT(1), .OVERSAMPLE(16)
    ) dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .rx(rx_a), .rx_if(a_if.master)
    );

    zrb_uart_rx_os #(
        .NUM_BITS(7), .PARITY("EVEN"), .STOP_BIT(2), .OVERSAMPLE(16)
    ) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .rx(rx_b), .rx_if(b_if.master)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk every div clocks.
    always @(negedge clk) begin
        ecnt = (ecnt + 1 >= div) ? 0 : ecnt + 1;
        clk_en = (ecnt == 0);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Scoreboard monitors: pop expected frames on each valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (busy_chk_a) begin
            chk("a busy after valid", 32'(a_if.busy), 32'd0);
            busy_chk_a = 1'b0;
        end
        if (a_if.valid === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a unexpected valid", 32'(a_if.data_out), 32'h1ff);
                chk("a unexpected valid count", 32'd1, 32'd0 + 32'(qa.size()));
            end else begin
                e = qa.pop_front();
                chk("a data_out", 32'(a_if.data_out), 32'(e.d));
                chk("a parity_err", 32'(a_if.parity_err), 32'(e.pe));
                chk("a frame_err", 32'(a_if.frame_err), 32'(e.fe));
                chk("a break with valid", 32'(a_if.break_det), 32'd0);
                busy_chk_a = 1'b1;
            end
        end
        if (a_if.break_det === 1'b1) brk_a_cyc++;
        if (busy_chk_b) begin
            chk("b busy after valid", 32'(b_if.busy), 32'd0);
            busy_chk_b = 1'b0;
        end
        if (b_if.valid === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b unexpected valid", 32'(b_if.data_out), 32'h1ff);
            end else begin
                e = qb.pop_front();
                chk("b data_out", 32'(b_if.data_out), 32'(e.d));
                chk("b parity_err", 32'(b_if.parity_err), 32'(e.pe));
                chk("b frame_err", 32'(b_if.frame_err), 32'(e.fe));
                busy_chk_b = 1'b1;
            end
        end
        if (b_if.break_det === 1'b1) brk_b_cyc++;
    end

    task automatic drive(input int dut, input logic lvl, input int n);
        if (dut == 0) rx_a = lvl;
        else rx_b = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int dut, input logic [8:0] d, input int nb, input bit has_par,
                        input logic par, input int ns, input logic [1:0] stops);
        int bt;
        bt = 16 * div;
        drive(dut, 1'b0, bt);
        for (int i = 0; i < nb; i++) drive(dut, d[i], bt);
        if (has_par) drive(dut, par, bt);
        for (int i = 0; i < ns; i++) drive(dut, stops[i], bt);
        if (dut == 0) rx_a = 1'b1;
        else rx_b = 1'b1;
    endtask

    task automatic drain(input int dut);
        for (int i = 0; i < 2000; i++) begin
            if (((dut == 0) ? qa.size() : qb.size()) == 0) break;
            @(negedge clk);
        end
        if (dut == 0) begin
            chk("a frames pending", 32'(qa.size()), 32'd0);
            qa.delete();
        end else begin
            chk("b frames pending", 32'(qb.size()), 32'd0);
            qb.delete();
        end
    endtask

    task automatic push(input int dut, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d;
        e.pe = pe;
        e.fe = fe;
        if (dut == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        logic [8:0] rd;
        reset = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset data_out", 32'(a_if.data_out), 32'd0);
        chk("reset valid", 32'(a_if.valid), 32'd0);
        chk("reset parity_err", 32'(a_if.parity_err), 32'd0);
        chk("reset frame_err", 32'(a_if.frame_err), 32'd0);
        chk("reset break_det", 32'(a_if.break_det), 32'd0);
        chk("reset busy", 32'(a_if.busy), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        //             dut  data    par   stops  div  exp_d   pe    fe
        tv[0]  = '{0, 9'h0a5, 1'b0, 2'b01, 1, 9'h0a5, 1'b0, 1'b0};
        tv[1]  = '{0, 9'h055, 1'b0, 2'b00, 1, 9'h055, 1'b0, 1'b1};
        tv[2]  = '{0, 9'h03c, 1'b0, 2'b01, 1, 9'h03c, 1'b0, 1'b0};
        tv[3]  = '{0, 9'h096, 1'b0, 2'b01, 3, 9'h096, 1'b0, 1'b0};
        tv[4]  = '{0, 9'h000, 1'b0, 2'b01, 1, 9'h000, 1'b0, 1'b0};
        tv[5]  = '{0, 9'h080, 1'b0, 2'b00, 1, 9'h080, 1'b0, 1'b1};
        tv[6]  = '{1, 9'h041, 1'b1, 2'b11, 1, 9'h041, 1'b1, 1'b0};
        tv[7]  = '{1, 9'h041, 1'b0, 2'b11, 1, 9'h041, 1'b0, 1'b0};
        tv[8]  = '{1, 9'h07f, 1'b1, 2'b10, 1, 9'h07f, 1'b0, 1'b1};
        tv[9]  = '{1, 9'h02a, 1'b1, 2'b01, 2, 9'h02a, 1'b0, 1'b1};
        tv[10] = '{1, 9'h000, 1'b1, 2'b11, 1, 9'h000, 1'b1, 1'b0};

        foreach (tv[k]) begin
            div = tv[k].dv;
            repeat (8) @(negedge clk);
            push(tv[k].dut, tv[k].xd, tv[k].xpe, tv[k].xfe);
            if (tv[k].dut == 0) send(0, tv[k].d, 8, 1'b0, 1'b0, 1, tv[k].stops);
            else send(1, tv[k].d, 7, 1'b1, tv[k].par, 2, tv[k].stops);
            drain(tv[k].dut);
            repeat (20) @(negedge clk);
        end
        div = 1;
        repeat (4) @(negedge clk);

        // Glitch shorter than half a bit: rejected, then a real frame.
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 10);
        chk("glitch busy cleared", 32'(a_if.busy), 32'd0);
        push(0, 9'h03c, 1'b0, 1'b0);
        send(0, 9'h03c, 8, 1'b0, 1'b0, 1, 2'b01);
        drain(0);
        repeat (20) @(negedge clk);

        // Break: line low for three frame times.
        b0 = brk_a_cyc;
        drive(0, 1'b0, 480);
        chk("break busy while low", 32'(a_if.busy), 32'd1);
        drive(0, 1'b1, 40);
        chk("break pulse cycles", 32'(brk_a_cyc - b0), 32'd1);
        chk("break keeps data_out", 32'(a_if.data_out), 32'h03c);
        chk("break busy released", 32'(a_if.busy), 32'd0);
        push(0, 9'h0ff, 1'b0, 1'b0);
        send(0, 9'h0ff, 8, 1'b0, 1'b0, 1, 2'b01);
        drain(0);
        repeat (20) @(negedge clk);

        // Back-to-back frames, no idle gap between stop and next start.
        push(0, 9'h001, 1'b0, 1'b0);
        push(0, 9'h080, 1'b0, 1'b0);
        send(0, 9'h001, 8, 1'b0, 1'b0, 1, 2'b01);
        send(0, 9'h080, 8, 1'b0, 1'b0, 1, 2'b01);
        chk("b2b frames pending", 32'(qa.size()), 32'd0);

        // Third frame aborted by reset during data bit 4.
        rd = 9'h05a;
        drive(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive(0, rd[i], 16);
        drive(0, rd[4], 8);
        chk("mid-frame busy", 32'(a_if.busy), 32'd1);
        chk("pre-reset b parity_err", 32'(b_if.parity_err), 32'd1);
        reset = 1'b0;
        #1;
        chk("async reset data_out", 32'(a_if.data_out), 32'd0);
        chk("async reset valid", 32'(a_if.valid), 32'd0);
        chk("async reset frame_err", 32'(a_if.frame_err), 32'd0);
        chk("async reset break_det", 32'(a_if.break_det), 32'd0);
        chk("async reset busy", 32'(a_if.busy), 32'd0);
        chk("async reset b parity_err", 32'(b_if.parity_err), 32'd0);
        chk("async reset b data_out", 32'(b_if.data_out), 32'd0);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("after reset no frame", 32'(a_if.data_out), 32'd0);

        // Recovery frame after reset release.
        push(0, 9'h0c3, 1'b0, 1'b0);
        send(0, 9'h0c3, 8, 1'b0, 1'b0, 1, 2'b01);
        drain(0);
        repeat (20) @(negedge clk);
        chk("no b breaks", 32'(brk_b_cyc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
